seg_scan_ctrl: RTL and testbench

- Time-multiplexed controller for the board's common-anode 4-digit seven-segment display.
- Shares a single hex-to-seven-segment decoder instance across all digits. Each digit is driven in turn, with a guard interval between digits to suppress ghosting.
- Display data is double-buffered: new values from the game FSM are committed only at a digit boundary, so no digit ever shows a torn value.

---
 rtl/disp_pkg.sv | 18 +
 rtl/seg_scan_ctrl_if.sv | 30 +++
 rtl/seg_scan_ctrl_dec.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants for the seven-segment scan controller
// Purpose: segment/anode idle patterns and scan FSM state encoding.
package disp_pkg;

    // Widest display this controller supports; anode constants are sliced down.
    localparam int MAX_DIGITS = 8;

    // All segments dark (active-low outputs).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // All anodes off (active-low outputs); slice to NUM_DIGITS at the use site.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Scan FSM state encoding.
    localparam logic [0:0] GUARD = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display-data load/commit bus for seg_scan_ctrl
// Ports (signals):
//   load       - single-cycle strobe capturing data_in/blank_in into the pending buffer
//   data_in    - hex nibbles, digit 0 in bits [3:0]
//   blank_in   - per-digit dark mask, 1 = digit dark
//   commit_ack - one-cycle pulse when pending data becomes displayed data
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    commit_ack;

    // master: the producer of display values (game FSM)
    modport master (
        output load,
        output data_in,
        output blank_in,
        input  commit_ack
    );

    // slave: the scan controller
    modport slave (
        input  load,
        input  data_in,
        input  blank_in,
        output commit_ack
    );
endinterface

// File: rtl/seg_scan_ctrl_dec.sv
// rtl/seg_scan_ctrl_dec.sv - hex to active-low seven-segment decoder
// Ports:
//   bcd  in  6  zero-extended nibble
//   sseg out 7  segments {a,b,c,d,e,f,g}, active-low
module BCDtoSSeg (
    input  logic [5:0] bcd,
    output logic [6:0] sseg
);
    always_comb begin
        case (bcd)
            6'h00:   sseg = 7'b0000001;
            6'h01:   sseg = 7'b1001111;
            6'h02:   sseg = 7'b0010010;
            6'h03:   sseg = 7'b0000110;
            6'h04:   sseg = 7'b1001100;
            6'h05:   sseg = 7'b0100100;
            6'h06:   sseg = 7'b0100000;
            6'h07:   sseg = 7'b0001111;
            6'h08:   sseg = 7'b0000000;
            6'h09:   sseg = 7'b0000100;
            6'h0A:   sseg = 7'b0001000;
            6'h0B:   sseg = 7'b1100000;
            6'h0C:   sseg = 7'b0110001;
            6'h0D:   sseg = 7'b1000010;
            6'h0E:   sseg = 7'b0110000;
            6'h0F:   sseg = 7'b0111000;
            // Only reachable for codes above 0xF, which the nibble mux never produces.
            default: sseg = 7'b0000000;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed common-anode seven-segment scan controller
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   host       slave modport of seg_scan_ctrl_if (load/data_in/blank_in/commit_ack)
//   an         out  NUM_DIGITS anode enables, active-low, registered
//   sseg       out  7 segments {a..g}, active-low, registered
//   digit_idx  out  digit currently scanned
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    seg_scan_ctrl_if.slave                host,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    sseg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PS_W  = $clog2(SCAN_DIV);

    localparam logic [PS_W-1:0]       PS_LAST    = PS_W'(SCAN_DIV - 1);
    localparam logic [PS_W-1:0]       GUARD_LAST = PS_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]      DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE    = AN_OFF[NUM_DIGITS-1:0];

    logic [0:0]              state_q, state_d;
    logic [PS_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_q, pend_d;
    logic                    commit_ack_q, commit_ack_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              sseg_q, sseg_d;

    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic [6:0]              dec_seg;
    logic                    slot_end;

    // One decoder shared by every digit; the mux follows the scan index.
    assign cur_nibble = disp_data_q[{digit_q, 2'b00} +: 4];
    assign cur_blank  = disp_blank_q[digit_q];

    BCDtoSSeg u_dec (
        .bcd  ({2'b00, cur_nibble}),
        .sseg (dec_seg)
    );

    assign slot_end = (state_q == DRIVE) && (presc_q == PS_LAST);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q + 1'b1;
        digit_d      = digit_q;
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_d       = pend_q;
        commit_ack_d = 1'b0;
        an_d         = AN_IDLE;
        sseg_d       = sseg_q;

        if (state_q == GUARD) begin
            if (presc_q == GUARD_LAST) begin
                state_d = DRIVE;
            end
        end else if (slot_end) begin
            presc_d = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            state_d = GUARD;
        end

        if (host.load) begin
            pend_data_d  = host.data_in;
            pend_blank_d = host.blank_in;
            pend_d       = 1'b1;
        end

        // Commit only at the digit boundary so a digit never shows a torn value.
        // A load arriving on this same edge bypasses the pending buffer.
        if (slot_end && (pend_q || host.load)) begin
            disp_data_d  = host.load ? host.data_in  : pend_data_q;
            disp_blank_d = host.load ? host.blank_in : pend_blank_q;
            pend_d       = 1'b0;
            commit_ack_d = 1'b1;
        end

        // Segments change only while anodes are dark; held through DRIVE.
        if (state_q == GUARD) begin
            sseg_d = cur_blank ? SEG_BLANK : dec_seg;
        end else if (!cur_blank) begin
            an_d = ~(NUM_DIGITS'(1) << digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GUARD;
            presc_q      <= '0;
            digit_q      <= '0;
            disp_data_q  <= '0;
            disp_blank_q <= '1;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_q       <= 1'b0;
            commit_ack_q <= 1'b0;
            an_q         <= AN_IDLE;
            sseg_q       <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_q       <= pend_d;
            commit_ack_q <= commit_ack_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
        end
    end

    assign host.commit_ack = commit_ack_q;
    assign an              = an_q;
    assign sseg            = sseg_q;
    assign digit_idx       = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an;
    logic [6:0] sseg;
    logic [1:0] digit_idx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .an        (an),
        .sseg      (sseg),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After this returns the bench is in cycle 1 (prescaler 0, digit 0).
    task automatic do_reset;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.blank_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        bus.load     = 1'b1;
        bus.data_in  = d;
        bus.blank_in = b;
        tick();
        bus.load = 1'b0;
    endtask

    // Returns at the first cycle of a new slot (prescaler 0).
    task automatic wait_slot_start(output bit ok);
        logic [1:0] prev;
        ok   = 1'b0;
        prev = digit_idx;
        for (int i = 0; i < 16 && !ok; i++) begin
            tick();
            if (digit_idx !== prev) ok = 1'b1;
            prev = digit_idx;
        end
    endtask

    // Captures outputs at prescaler 1, 2 and 3 of the next slot for digit d.
    task automatic observe_slot(input int d, output bit found,
                                output logic [3:0] an_g1, output logic [3:0] an_g2,
                                output logic [3:0] an_dr,
                                output logic [6:0] seg_g, output logic [6:0] seg_dr);
        logic [1:0] prev;
        found  = 1'b0;
        prev   = digit_idx;
        an_g1  = 'x;
        an_g2  = 'x;
        an_dr  = 'x;
        seg_g  = 'x;
        seg_dr = 'x;
        for (int i = 0; i < 48 && !found; i++) begin
            tick();
            if (int'(digit_idx) == d && prev != digit_idx) found = 1'b1;
            prev = digit_idx;
        end
        if (found) begin
            tick();
            an_g1 = an;
            seg_g = sseg;
            tick();
            an_g2 = an;
            tick();
            an_dr  = an;
            seg_dr = sseg;
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (sseg !== 7'b1111111) begin errors++; $display("FAIL reset_sseg got %b want 1111111", sseg); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_digit_idx got %0d want 0", digit_idx); end
        checks++; if (bus.commit_ack !== 1'b0) begin errors++; $display("FAIL reset_commit_ack got %b want 0", bus.commit_ack); end
    endtask

    task automatic test_no_load;
        int bad_an, bad_seg, acks;
        bad_an = 0; bad_seg = 0; acks = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (an !== 4'b1111) bad_an++;
            if (sseg !== 7'b1111111) bad_seg++;
            if (bus.commit_ack !== 1'b0) acks++;
            tick();
        end
        checks++; if (bad_an != 0) begin errors++; $display("FAIL noload_an got %0d lit cycles want 0", bad_an); end
        checks++; if (bad_seg != 0) begin errors++; $display("FAIL noload_sseg got %0d lit cycles want 0", bad_seg); end
        checks++; if (acks != 0) begin errors++; $display("FAIL noload_ack got %0d pulses want 0", acks); end
    endtask

    task automatic test_load_basic;
        logic [6:0] exp_seg [4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] a1, a2, a3;
        logic [6:0] s1, s3;
        bit found;
        int ack_cnt, ack_cyc;
        ack_cnt = 0; ack_cyc = 0;
        do_reset();
        repeat (4) tick();
        do_load(16'h3210, 4'b0000);
        while (cyc < 40) begin
            if (bus.commit_ack === 1'b1) begin ack_cnt++; ack_cyc = cyc; end
            tick();
        end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL basic_ack_count got %0d want 1", ack_cnt); end
        checks++; if (ack_cyc != 9) begin errors++; $display("FAIL basic_ack_cycle got %0d want 9", ack_cyc); end
        for (int d = 0; d < 4; d++) begin
            observe_slot(d, found, a1, a2, a3, s1, s3);
            checks++; if (!found) begin errors++; $display("FAIL basic_slot_timeout digit %0d got none want slot", d); end
            checks++; if (a1 !== 4'b1111 || a2 !== 4'b1111) begin errors++; $display("FAIL basic_guard_an digit %0d got %b/%b want 1111", d, a1, a2); end
            checks++; if (a3 !== exp_an[d]) begin errors++; $display("FAIL basic_drive_an digit %0d got %b want %b", d, a3, exp_an[d]); end
            checks++; if (s1 !== exp_seg[d] || s3 !== exp_seg[d]) begin errors++; $display("FAIL basic_sseg digit %0d got %b/%b want %b", d, s1, s3, exp_seg[d]); end
        end
    endtask

    task automatic test_blank_mask;
        logic [3:0] exp_an [4] = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
        logic [6:0] exp_seg [4] = '{7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000};
        logic [3:0] a1, a2, a3;
        logic [6:0] s1, s3;
        bit found, acked;
        acked = 1'b0;
        do_load(16'h8888, 4'b0101);
        for (int i = 0; i < 20 && !acked; i++) begin
            if (bus.commit_ack === 1'b1) acked = 1'b1;
            else tick();
        end
        checks++; if (!acked) begin errors++; $display("FAIL blank_ack got none want pulse"); end
        for (int d = 0; d < 4; d++) begin
            observe_slot(d, found, a1, a2, a3, s1, s3);
            checks++; if (!found) begin errors++; $display("FAIL blank_slot_timeout digit %0d got none want slot", d); end
            checks++; if (a1 !== 4'b1111 || a2 !== 4'b1111) begin errors++; $display("FAIL blank_guard_an digit %0d got %b/%b want 1111", d, a1, a2); end
            checks++; if (a3 !== exp_an[d]) begin errors++; $display("FAIL blank_drive_an digit %0d got %b want %b", d, a3, exp_an[d]); end
            checks++; if (s1 !== exp_seg[d] || s3 !== exp_seg[d]) begin errors++; $display("FAIL blank_sseg digit %0d got %b/%b want %b", d, s1, s3, exp_seg[d]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_seg [4] = '{7'b0111000, 7'b0110000, 7'b0110000, 7'b1100000};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] a1, a2, a3;
        logic [6:0] s1, s3;
        bit ok, found;
        int acks;
        acks = 0;
        wait_slot_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_slot_timeout got none want slot"); end
        tick();
        do_load(16'hAAAA, 4'b0000);
        do_load(16'hBEEF, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            if (bus.commit_ack === 1'b1) acks++;
            tick();
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL b2b_ack_count got %0d want 1", acks); end
        for (int d = 0; d < 4; d++) begin
            observe_slot(d, found, a1, a2, a3, s1, s3);
            checks++; if (!found) begin errors++; $display("FAIL b2b_slot_timeout digit %0d got none want slot", d); end
            checks++; if (a3 !== exp_an[d]) begin errors++; $display("FAIL b2b_drive_an digit %0d got %b want %b", d, a3, exp_an[d]); end
            checks++; if (s1 !== exp_seg[d] || s3 !== exp_seg[d]) begin errors++; $display("FAIL b2b_sseg digit %0d got %b/%b want %b", d, s1, s3, exp_seg[d]); end
        end
    endtask

    task automatic test_commit_edge;
        logic [3:0] exp_an;
        bit ok;
        int acks;
        acks = 0;
        wait_slot_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL edge_slot_timeout got none want slot"); end
        repeat (7) tick();
        // Load is high during the last DRIVE cycle, i.e. on the boundary edge.
        do_load(16'h4444, 4'b0000);
        checks++; if (bus.commit_ack !== 1'b1) begin errors++; $display("FAIL edge_ack_now got %b want 1", bus.commit_ack); end
        exp_an = 4'b1111;
        exp_an[digit_idx] = 1'b0;
        tick();
        checks++; if (bus.commit_ack !== 1'b0) begin errors++; $display("FAIL edge_ack_width got %b want 0", bus.commit_ack); end
        checks++; if (sseg !== 7'b1001100) begin errors++; $display("FAIL edge_sseg got %b want 1001100", sseg); end
        tick();
        tick();
        checks++; if (an !== exp_an) begin errors++; $display("FAIL edge_drive_an got %b want %b", an, exp_an); end
        for (int i = 0; i < 24; i++) begin
            if (bus.commit_ack === 1'b1) acks++;
            tick();
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL edge_flag_cleared got %0d pulses want 0", acks); end
    endtask

    task automatic test_reset_mid_drive;
        bit ok;
        int bad_an, acks;
        bad_an = 0; acks = 0;
        wait_slot_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_slot_timeout got none want slot"); end
        repeat (3) tick();
        checks++; if (an === 4'b1111) begin errors++; $display("FAIL rstmid_pre_drive got %b want one anode low", an); end
        do_load(16'h1234, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rstmid_an got %b want 1111", an); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL rstmid_digit_idx got %0d want 0", digit_idx); end
        checks++; if (sseg !== 7'b1111111) begin errors++; $display("FAIL rstmid_sseg got %b want 1111111", sseg); end
        for (int i = 0; i < 60; i++) begin
            if (an !== 4'b1111) bad_an++;
            if (bus.commit_ack !== 1'b0) acks++;
            tick();
        end
        checks++; if (bad_an != 0) begin errors++; $display("FAIL rstmid_stays_blank got %0d lit cycles want 0", bad_an); end
        checks++; if (acks != 0) begin errors++; $display("FAIL rstmid_pending_dropped got %0d pulses want 0", acks); end
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.blank_in = '0;
        test_reset();
        test_no_load();
        test_load_basic();
        test_blank_mask();
        test_back_to_back();
        test_commit_edge();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
